// File: rtl/mmio_uart_ctrl_if.sv
// CPU-side MMIO bus plus uart byte-stream handshakes for mmio_uart_ctrl.
//
// Handshake rule for both uart streams: a byte moves on a rising clk edge
// where valid and ready are both high. The producer holds valid and data
// stable until that edge. Valid never depends combinationally on ready.
interface mmio_uart_ctrl_if;
  // CPU MEM-stage access, same timing as the dmem port
  logic        mmio_en;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_din;
  logic [31:0] mmio_dout;
  logic        inst_retire;
  // uart transmit stream (controller produces)
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  // uart receive stream (controller consumes)
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  // CPU + uart side
  modport master (
    output mmio_en, mmio_we, mmio_addr, mmio_din, inst_retire,
    input  mmio_dout,
    input  uart_tx_data, uart_tx_valid,
    output uart_tx_ready,
    output uart_rx_data, uart_rx_valid,
    input  uart_rx_ready
  );

  // controller side
  modport slave (
    input  mmio_en, mmio_we, mmio_addr, mmio_din, inst_retire,
    output mmio_dout,
    output uart_tx_data, uart_tx_valid,
    input  uart_tx_ready,
    input  uart_rx_data, uart_rx_valid,
    output uart_rx_ready
  );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller: decodes CPU accesses in the I/O region, sequences a
// single-byte uart TX holding register and RX buffer, and provides
// free-running cycle and retired-instruction counters. Load data is
// registered (one-cycle latency, like dmem) and reflects state before the
// edge that captures it.
module mmio_uart_ctrl #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mmio_uart_ctrl_if.slave bus,
  output logic            dbg_tx_state_o
);

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

  // Word indices (addr[27:2]) of the mapped registers
  localparam logic [25:0] W_CTRL = 26'd0;
  localparam logic [25:0] W_RX   = 26'd1;
  localparam logic [25:0] W_TX   = 26'd2;
  localparam logic [25:0] W_CYC  = 26'd4;
  localparam logic [25:0] W_INS  = 26'd5;
  localparam logic [25:0] W_CLR  = 26'd6;

  tx_state_t             tx_state_q, tx_state_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  rx_full_q, rx_full_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]  ins_q, ins_d;
  logic [31:0]           dout_q, dout_d;

  logic        hit;
  logic        is_load;
  logic        is_store;
  logic [25:0] word;
  logic        tx_store;
  logic        cnt_clear;
  logic        rx_pop;
  logic        rx_take;
  logic        tx_pending;
  logic [31:0] rdata;
  logic [31:0] cyc_rd;
  logic [31:0] ins_rd;

  // Byte-offset bits and upper store-data lanes are deliberately ignored
  logic unused_bits;
  assign unused_bits = ^{bus.mmio_addr[1:0], bus.mmio_din[31:8]};

  // Address decode: only the top nibble selects the region
  always_comb begin
    hit       = bus.mmio_en && (bus.mmio_addr[31:28] == MMIO_BASE[31:28]);
    word      = bus.mmio_addr[27:2];
    is_load   = hit && (bus.mmio_we == 4'b0000);
    is_store  = hit && (bus.mmio_we != 4'b0000);
    tx_store  = is_store && (word == W_TX) && bus.mmio_we[0];
    cnt_clear = is_store && (word == W_CLR);
    rx_pop    = is_load && (word == W_RX) && rx_full_q;
    rx_take   = bus.uart_rx_valid && !rx_full_q;
  end

  // TX FSM: hold one byte until the uart accepts it; stores while pending are dropped
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_store) begin
          tx_data_d  = bus.mmio_din[7:0];
          tx_state_d = TX_PEND;
        end
      end
      TX_PEND: begin
        if (bus.uart_tx_ready) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX buffer: capture when empty; a load of the RX register empties it
  always_comb begin
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_take) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.uart_rx_data;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end
  end

  // Counters: clear wins over the same-cycle increment; both wrap naturally
  always_comb begin
    if (cnt_clear) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      cyc_d = cyc_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      ins_d = ins_q + {{(CNT_WIDTH-1){1'b0}}, bus.inst_retire};
    end
  end

  // Read mux on current (pre-edge) state; write-only and unmapped words read 0
  always_comb begin
    tx_pending = (tx_state_q == TX_PEND);
    cyc_rd     = 32'(cyc_q);
    ins_rd     = 32'(ins_q);
    rdata      = 32'h0;
    case (word)
      W_CTRL:  rdata = {30'b0, rx_full_q, !tx_pending};
      W_RX:    rdata = rx_full_q ? {24'b0, rx_byte_q} : 32'h0;
      W_CYC:   rdata = cyc_rd;
      W_INS:   rdata = ins_rd;
      default: rdata = 32'h0;
    endcase
    dout_d = is_load ? rdata : 32'h0;
  end

  // State registers; reset drops any byte in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= 8'h00;
      cyc_q      <= '0;
      ins_q      <= '0;
      dout_q     <= 32'h0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      cyc_q      <= cyc_d;
      ins_q      <= ins_d;
      dout_q     <= dout_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.mmio_dout     = dout_q;
    bus.uart_tx_data  = tx_data_q;
    bus.uart_tx_valid = (tx_state_q == TX_PEND);
    bus.uart_rx_ready = !rx_full_q;
    dbg_tx_state_o    = tx_state_q;
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: loads push their expected value into a
// queue when issued and are popped and compared when mmio_dout is valid.
// A second instance with 8-bit counters exercises counter wrap-around.
module tb_mmio_uart_ctrl;

  logic clk;
  logic rst;
  logic dbg_m;
  logic dbg_s;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          chk_cnt;
  int          pass_cnt;

  mmio_uart_ctrl_if m_if ();
  mmio_uart_ctrl_if s_if ();

  mmio_uart_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (m_if.slave),
    .dbg_tx_state_o (dbg_m)
  );

  mmio_uart_ctrl #(.CNT_WIDTH(8)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .bus            (s_if.slave),
    .dbg_tx_state_o (dbg_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic idle_bus();
    m_if.mmio_en   = 1'b0;
    m_if.mmio_we   = 4'b0000;
    m_if.mmio_addr = 32'h0;
    m_if.mmio_din  = 32'h0;
    s_if.mmio_en   = 1'b0;
    s_if.mmio_we   = 4'b0000;
    s_if.mmio_addr = 32'h0;
    s_if.mmio_din  = 32'h0;
  endtask

  // Issue a load for one cycle; the result is checked at the following negedge
  task automatic do_load(input bit sel, input logic [31:0] addr, input logic [31:0] exp,
                         input string tag);
    logic [31:0] obs;
    if (sel) begin
      s_if.mmio_en = 1'b1; s_if.mmio_we = 4'b0000; s_if.mmio_addr = addr;
    end else begin
      m_if.mmio_en = 1'b1; m_if.mmio_we = 4'b0000; m_if.mmio_addr = addr;
    end
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    idle_bus();
    obs = sel ? s_if.mmio_dout : m_if.mmio_dout;
    check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic do_store(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] we);
    if (sel) begin
      s_if.mmio_en = 1'b1; s_if.mmio_we = we; s_if.mmio_addr = addr; s_if.mmio_din = data;
    end else begin
      m_if.mmio_en = 1'b1; m_if.mmio_we = we; m_if.mmio_addr = addr; m_if.mmio_din = data;
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_push(input logic [7:0] b);
    m_if.uart_rx_data  = b;
    m_if.uart_rx_valid = 1'b1;
    @(negedge clk);
    m_if.uart_rx_valid = 1'b0;
    m_if.uart_rx_data  = 8'h00;
  endtask

  initial begin
    int r;
    chk_cnt  = 0;
    pass_cnt = 0;
    rst = 1'b1;
    idle_bus();
    m_if.inst_retire   = 1'b0;
    m_if.uart_tx_ready = 1'b0;
    m_if.uart_rx_data  = 8'h00;
    m_if.uart_rx_valid = 1'b0;
    s_if.inst_retire   = 1'b0;
    s_if.uart_tx_ready = 1'b1;
    s_if.uart_rx_data  = 8'h00;
    s_if.uart_rx_valid = 1'b0;
    tick(3);

    // reset values
    check("rst_dout", m_if.mmio_dout, 32'h0);
    check("rst_tx_valid", {31'b0, m_if.uart_tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, m_if.uart_tx_data}, 32'h0);
    check("rst_rx_ready", {31'b0, m_if.uart_rx_ready}, 32'h1);
    rst = 1'b0;

    // first loads after reset: counters at 0, ctrl idle
    do_load(0, 32'h8000_0010, 32'h0, "cyc_after_rst");
    do_load(0, 32'h8000_0014, 32'h0, "ins_after_rst");
    do_load(0, 32'h8000_0000, 32'h1, "ctrl_after_rst");

    // TX: byte held while uart not ready; second store dropped
    do_store(0, 32'h8000_0008, 32'h0000_0041, 4'b0001);
    check("tx_valid_pend", {31'b0, m_if.uart_tx_valid}, 32'h1);
    check("tx_data_pend", {24'b0, m_if.uart_tx_data}, 32'h41);
    check("tx_state_pend", {31'b0, dbg_m}, 32'h1);
    do_store(0, 32'h8000_0008, 32'h0000_0042, 4'b0001);
    check("tx_data_no_overwrite", {24'b0, m_if.uart_tx_data}, 32'h41);
    do_load(0, 32'h8000_0000, 32'h0, "ctrl_tx_pending");
    check("tx_valid_held", {31'b0, m_if.uart_tx_valid}, 32'h1);
    check("tx_data_held", {24'b0, m_if.uart_tx_data}, 32'h41);
    m_if.uart_tx_ready = 1'b1;
    tick(1);
    m_if.uart_tx_ready = 1'b0;
    check("tx_valid_drop", {31'b0, m_if.uart_tx_valid}, 32'h0);
    do_load(0, 32'h8000_0000, 32'h1, "ctrl_tx_done");

    // TX stores that must not launch a byte
    do_store(0, 32'h8000_0008, 32'h0000_00AA, 4'b0010);
    check("tx_no_we0", {31'b0, m_if.uart_tx_valid}, 32'h0);
    do_store(0, 32'h9000_0008, 32'h0000_00AA, 4'b0001);
    check("tx_nonhit", {31'b0, m_if.uart_tx_valid}, 32'h0);

    // unmapped / write-only / non-hit loads read 0; addr[1:0] ignored
    do_load(0, 32'h8000_000C, 32'h0, "unmapped_0c");
    do_load(0, 32'h8000_0008, 32'h0, "wo_tx_read");
    do_load(0, 32'h8000_0018, 32'h0, "wo_clr_read");
    do_load(0, 32'h0000_0000, 32'h0, "nonhit_load");
    do_load(0, 32'h8000_0003, 32'h1, "ctrl_unaligned");

    // RX: capture, ignore while full, pop, empty read
    rx_push(8'h5A);
    check("rx_ready_full", {31'b0, m_if.uart_rx_ready}, 32'h0);
    m_if.uart_rx_data  = 8'h77;
    m_if.uart_rx_valid = 1'b1;
    do_load(0, 32'h8000_0000, 32'h3, "ctrl_rx_full");
    m_if.uart_rx_valid = 1'b0;
    do_load(0, 32'h8000_0004, 32'h5A, "rx_pop");
    do_load(0, 32'h8000_0000, 32'h1, "ctrl_after_pop");
    check("rx_ready_after_pop", {31'b0, m_if.uart_rx_ready}, 32'h1);
    do_load(0, 32'h8000_0004, 32'h0, "rx_empty_load");

    // counters: 100 cycles with exactly 60 random retires
    do_store(0, 32'h8000_0018, 32'h0, 4'b1111);
    r = 60;
    for (int c = 100; c > 0; c--) begin
      m_if.inst_retire = ($urandom_range(c - 1, 0) < r);
      if (m_if.inst_retire) r--;
      @(negedge clk);
    end
    m_if.inst_retire = 1'b0;
    do_load(0, 32'h8000_0010, 32'd100, "cyc_100");
    do_load(0, 32'h8000_0014, 32'd60, "ins_60");

    // counter clear wins over same-cycle retire, then both count up
    m_if.inst_retire = 1'b1;
    do_store(0, 32'h8000_0018, 32'hDEAD_BEEF, 4'b0100);
    tick(3);
    do_load(0, 32'h8000_0014, 32'd3, "ins_after_clr");
    do_load(0, 32'h8000_0010, 32'd4, "cyc_after_clr");
    do_load(0, 32'h8000_0014, 32'd5, "ins_count_on");
    m_if.inst_retire = 1'b0;

    // asynchronous reset while TX pending and RX full
    do_store(0, 32'h8000_0008, 32'h0000_0033, 4'b0001);
    rx_push(8'h11);
    do_load(0, 32'h8000_0000, 32'h2, "ctrl_pend_full");
    check("pre_rst_tx_valid", {31'b0, m_if.uart_tx_valid}, 32'h1);
    check("pre_rst_rx_ready", {31'b0, m_if.uart_rx_ready}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", m_if.mmio_dout, 32'h0);
    check("arst_tx_valid", {31'b0, m_if.uart_tx_valid}, 32'h0);
    check("arst_tx_data", {24'b0, m_if.uart_tx_data}, 32'h0);
    check("arst_rx_ready", {31'b0, m_if.uart_rx_ready}, 32'h1);
    check("arst_tx_state", {31'b0, dbg_m}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_load(0, 32'h8000_0000, 32'h1, "ctrl_post_rst");
    do_load(0, 32'h8000_0004, 32'h0, "rx_post_rst");

    // 8-bit counter instance: reaches all-ones then wraps to 0
    do_store(1, 32'h8000_0018, 32'h0, 4'b0001);
    tick(255);
    do_load(1, 32'h8000_0010, 32'h0000_00FF, "cyc8_max");
    do_load(1, 32'h8000_0010, 32'h0000_0000, "cyc8_wrap");

    tick(2);
    check("scoreboard_empty", exp_q.size(), 32'h0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
